// File: rtl/mac_seq_pkg.sv
// Shared types and constants for the MAC sequencer: FSM states, product width,
// and accumulator saturation bounds.
package mac_seq_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    localparam int PROD_W = 17;

    function automatic longint acc_max(input int w);
        return (longint'(1) <<< (w - 1)) - longint'(1);
    endfunction

    function automatic longint acc_min(input int w);
        return -(longint'(1) <<< (w - 1));
    endfunction

endpackage

// File: rtl/mac_sequencer_if.sv
// Bundles the command, operand stream, multiplier and result handshakes of the
// MAC sequencer; slave is the sequencer side, master the surrounding logic.
interface mac_sequencer_if #(
    parameter int ACC_W = 24,
    parameter int LEN_W = 8
);
    logic             start;
    logic [LEN_W-1:0] len;
    logic             busy;
    logic             in_valid;
    logic             in_ready;
    logic [7:0]       a_mag;
    logic             a_sign;
    logic [7:0]       b_mag;
    logic             b_sign;
    logic [7:0]       mul_a;
    logic [7:0]       mul_b;
    logic             mul_asign;
    logic             mul_bsign;
    logic [15:0]      mul_m;
    logic             mul_sign;
    logic             out_valid;
    logic             out_ready;
    logic [ACC_W-1:0] out_acc;
    logic             out_sat;

    modport slave (
        input  start, len, in_valid, a_mag, a_sign, b_mag, b_sign,
               mul_m, mul_sign, out_ready,
        output busy, in_ready, mul_a, mul_b, mul_asign, mul_bsign,
               out_valid, out_acc, out_sat
    );

    modport master (
        output start, len, in_valid, a_mag, a_sign, b_mag, b_sign,
               mul_m, mul_sign, out_ready,
        input  busy, in_ready, mul_a, mul_b, mul_asign, mul_bsign,
               out_valid, out_acc, out_sat
    );
endinterface

// File: rtl/mac_sat_acc.sv
// Saturating two's-complement accumulator with a sticky saturation flag;
// the add is done one bit wider than the accumulator so overflow is visible.
module mac_sat_acc
    import mac_seq_pkg::*;
#(
    parameter int ACC_W = 24
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic signed [PROD_W-1:0] i_prod,
    input  logic                     i_valid,
    input  logic                     i_clear,
    output logic signed [ACC_W-1:0]  o_acc,
    output logic                     o_sat
);
    localparam logic signed [ACC_W:0] C_MAX = (ACC_W + 1)'(acc_max(ACC_W));
    localparam logic signed [ACC_W:0] C_MIN = (ACC_W + 1)'(acc_min(ACC_W));

    logic signed [ACC_W-1:0] r_acc;
    logic                    r_sat;
    logic signed [ACC_W:0]   w_sum;

    assign w_sum = {r_acc[ACC_W-1], r_acc}
                 + {{(ACC_W + 1 - PROD_W){i_prod[PROD_W-1]}}, i_prod};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_acc <= '0;
            r_sat <= 1'b0;
        end else if (i_clear) begin
            r_acc <= '0;
            r_sat <= 1'b0;
        end else if (i_valid) begin
            if (w_sum > C_MAX) begin
                r_acc <= C_MAX[ACC_W-1:0];
                r_sat <= 1'b1;
            end else if (w_sum < C_MIN) begin
                r_acc <= C_MIN[ACC_W-1:0];
                r_sat <= 1'b1;
            end else begin
                r_acc <= w_sum[ACC_W-1:0];
            end
        end
    end

    assign o_acc = r_acc;
    assign o_sat = r_sat;
endmodule

// File: rtl/mac_sequencer.sv
// Drives a shared sign-magnitude multiplier through an N-term dot product:
// operand register -> product register -> saturating accumulator.
//   state | meaning
//   IDLE  | waiting for start; result of last run still on out_acc
//   RUN   | accepting operand pairs until remaining hits zero
//   DRAIN | letting operand and product stages empty into the accumulator
//   DONE  | result valid, held until out_ready
module mac_sequencer
    import mac_seq_pkg::*;
#(
    parameter int ACC_W = 24,
    parameter int LEN_W = 8
) (
    input  logic            clk,
    input  logic            rst_n,
    mac_sequencer_if.slave  bus
);
    state_t                   r_state;
    logic [LEN_W-1:0]         r_rem;
    logic                     r_busy;
    logic                     r_in_ready;
    logic                     r_out_valid;

    logic                     r_op_vld;
    logic [7:0]               r_a;
    logic [7:0]               r_b;
    logic                     r_as;
    logic                     r_bs;
    logic                     r_prod_vld;
    logic signed [PROD_W-1:0] r_prod;

    logic                     w_hs;
    logic                     w_clear;
    logic signed [PROD_W-1:0] w_prod_mag;

    assign w_hs       = bus.in_valid & r_in_ready;
    assign w_clear    = (r_state == ST_IDLE) & bus.start;
    assign w_prod_mag = {1'b0, bus.mul_m};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_rem       <= '0;
            r_busy      <= 1'b0;
            r_in_ready  <= 1'b0;
            r_out_valid <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (bus.start) begin
                        r_busy <= 1'b1;
                        if (bus.len != '0) begin
                            r_state    <= ST_RUN;
                            r_rem      <= bus.len;
                            r_in_ready <= 1'b1;
                        end else begin
                            r_state     <= ST_DONE;
                            r_out_valid <= 1'b1;
                        end
                    end
                end
                ST_RUN: begin
                    if (w_hs) begin
                        r_rem <= r_rem - LEN_W'(1);
                        if (r_rem == LEN_W'(1)) begin
                            r_state    <= ST_DRAIN;
                            r_in_ready <= 1'b0;
                        end
                    end
                end
                ST_DRAIN: begin
                    if (!r_op_vld && !r_prod_vld) begin
                        r_state     <= ST_DONE;
                        r_out_valid <= 1'b1;
                    end
                end
                ST_DONE: begin
                    if (bus.out_ready) begin
                        r_state     <= ST_IDLE;
                        r_out_valid <= 1'b0;
                        r_busy      <= 1'b0;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    // Operand stage zeroes itself when empty so the multiplier inputs idle at 0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_op_vld   <= 1'b0;
            r_a        <= '0;
            r_b        <= '0;
            r_as       <= 1'b0;
            r_bs       <= 1'b0;
            r_prod_vld <= 1'b0;
            r_prod     <= '0;
        end else begin
            r_op_vld <= w_hs;
            if (w_hs) begin
                r_a  <= bus.a_mag;
                r_b  <= bus.b_mag;
                r_as <= bus.a_sign;
                r_bs <= bus.b_sign;
            end else begin
                r_a  <= '0;
                r_b  <= '0;
                r_as <= 1'b0;
                r_bs <= 1'b0;
            end
            r_prod_vld <= r_op_vld;
            r_prod     <= bus.mul_sign ? -w_prod_mag : w_prod_mag;
        end
    end

    mac_sat_acc #(.ACC_W(ACC_W)) u_acc (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_prod  (r_prod),
        .i_valid (r_prod_vld),
        .i_clear (w_clear),
        .o_acc   (bus.out_acc),
        .o_sat   (bus.out_sat)
    );

    assign bus.busy      = r_busy;
    assign bus.in_ready  = r_in_ready;
    assign bus.out_valid = r_out_valid;
    assign bus.mul_a     = r_a;
    assign bus.mul_b     = r_b;
    assign bus.mul_asign = r_as;
    assign bus.mul_bsign = r_bs;
endmodule

// File: tb/tb_mac_sequencer.sv
// Self-checking bench for mac_sequencer: directed test-plan scenarios plus
// randomized runs checked against an integer dot-product model.
module tb_mac_sequencer;
    localparam int ACC_W = 24;
    localparam int LEN_W = 8;
    localparam longint MAXV = (longint'(1) <<< (ACC_W - 1)) - 1;
    localparam longint MINV = -(longint'(1) <<< (ACC_W - 1));

    logic clk = 1'b0;
    logic rst_n;
    int   n_cmp = 0;
    int   n_err = 0;

    int unsigned am [256];
    int unsigned bm [256];
    bit          asg[256];
    bit          bsg[256];

    mac_sequencer_if #(.ACC_W(ACC_W), .LEN_W(LEN_W)) vif ();

    mac_sequencer #(.ACC_W(ACC_W), .LEN_W(LEN_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (vif)
    );

    always #5 clk = ~clk;

    // External combinational sign-magnitude multiplier.
    assign vif.mul_m    = 16'(vif.mul_a) * 16'(vif.mul_b);
    assign vif.mul_sign = vif.mul_asign ^ vif.mul_bsign;

    function automatic void model(input int n, output longint acc, output bit sat);
        longint p;
        acc = 0;
        sat = 0;
        for (int i = 0; i < n; i++) begin
            p = longint'(am[i]) * longint'(bm[i]);
            if (asg[i] != bsg[i]) p = -p;
            acc = acc + p;
            if (acc > MAXV) begin acc = MAXV; sat = 1; end
            if (acc < MINV) begin acc = MINV; sat = 1; end
        end
    endfunction

    function automatic void set_pair(input int i, input int unsigned a, input bit as,
                                     input int unsigned b, input bit bs);
        am[i] = a; asg[i] = as; bm[i] = b; bsg[i] = bs;
    endfunction

    // gap_mode: 0 = in_valid held high, 1 = two idle cycles between pairs, 2 = random gaps.
    task automatic do_run(input int n, input int gap_mode, input bit chk_lat, input string tag,
                          output longint got_acc, output bit got_sat);
        longint exp_acc;
        bit     exp_sat;
        bit     hs;
        int     t = 0;
        int     idx = 0;
        int     gap = 0;
        int     first_t = 0;
        model(n, exp_acc, exp_sat);
        @(negedge clk);
        vif.start = 1'b1;
        vif.len   = LEN_W'(n);
        @(posedge clk);
        @(negedge clk);
        vif.start = 1'b0;
        while (idx < n && t < 4000) begin
            if (gap > 0) begin
                vif.in_valid = 1'b0;
                if (gap == 1) begin
                    n_cmp++;
                    if ({vif.mul_a, vif.mul_b, vif.mul_asign, vif.mul_bsign} !== 18'd0) begin
                        n_err++;
                        $display("FAIL %s bubble_mul: got a=%0d b=%0d as=%0b bs=%0b want all 0",
                                 tag, vif.mul_a, vif.mul_b, vif.mul_asign, vif.mul_bsign);
                    end
                end
                gap--;
            end else if (gap_mode == 2 && $urandom_range(0, 3) == 0) begin
                vif.in_valid = 1'b0;
            end else begin
                vif.in_valid = 1'b1;
                vif.a_mag  = 8'(am[idx]);
                vif.a_sign = asg[idx];
                vif.b_mag  = 8'(bm[idx]);
                vif.b_sign = bsg[idx];
            end
            hs = vif.in_valid && vif.in_ready;
            @(posedge clk);
            t++;
            if (hs) begin
                if (idx == 0) first_t = t;
                idx++;
                if (gap_mode == 1) gap = 2;
            end
            @(negedge clk);
        end
        vif.in_valid = 1'b0;
        n_cmp++;
        if (idx != n) begin
            n_err++;
            $display("FAIL %s accept_timeout: got %0d pairs accepted want %0d", tag, idx, n);
        end
        n_cmp++;
        if (vif.in_ready !== 1'b0) begin
            n_err++;
            $display("FAIL %s in_ready_after_last: got %b want 0", tag, vif.in_ready);
        end
        while (vif.out_valid !== 1'b1 && t < 5000) begin
            @(posedge clk);
            t++;
            @(negedge clk);
        end
        n_cmp++;
        if (vif.out_valid !== 1'b1) begin
            n_err++;
            $display("FAIL %s out_valid_timeout: got %b want 1", tag, vif.out_valid);
        end
        // Accept cycle is cycle 0; the result is visible in cycle 6, i.e. 5 edges later.
        if (chk_lat) begin
            n_cmp++;
            if (t - first_t != 5) begin
                n_err++;
                $display("FAIL %s latency: got %0d edges want 5", tag, t - first_t);
            end
        end
        got_acc = longint'($signed(vif.out_acc));
        got_sat = vif.out_sat;
        n_cmp++;
        if (got_acc !== exp_acc || got_sat !== exp_sat) begin
            n_err++;
            $display("FAIL %s result: got acc=%0d sat=%0b want acc=%0d sat=%0b",
                     tag, got_acc, got_sat, exp_acc, exp_sat);
        end
        @(posedge clk);
        @(negedge clk);
        n_cmp++;
        if (vif.out_valid !== 1'b0 || vif.busy !== 1'b0 || longint'($signed(vif.out_acc)) !== exp_acc) begin
            n_err++;
            $display("FAIL %s after_accept: got valid=%b busy=%b acc=%0d want 0 0 %0d",
                     tag, vif.out_valid, vif.busy, $signed(vif.out_acc), exp_acc);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        n_cmp++;
        if ({vif.busy, vif.in_ready, vif.out_valid, vif.out_sat} !== 4'b0 || vif.out_acc !== '0 ||
            {vif.mul_a, vif.mul_b, vif.mul_asign, vif.mul_bsign} !== 18'd0) begin
            n_err++;
            $display("FAIL reset_state: got busy=%b rdy=%b ov=%b sat=%b acc=%0d mul_a=%0d mul_b=%0d want all 0",
                     vif.busy, vif.in_ready, vif.out_valid, vif.out_sat, vif.out_acc, vif.mul_a, vif.mul_b);
        end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_contig();
        longint acc; bit sat;
        set_pair(0, 3, 0, 5, 0);
        set_pair(1, 2, 1, 7, 0);
        set_pair(2, 255, 1, 255, 1);
        do_run(3, 0, 1'b1, "contig", acc, sat);
        n_cmp++;
        if (acc !== 65026 || sat !== 1'b0) begin
            n_err++;
            $display("FAIL contig_value: got %0d/%0b want 65026/0", acc, sat);
        end
    endtask

    task automatic test_gaps();
        longint acc; bit sat;
        do_run(3, 1, 1'b0, "gaps", acc, sat);
        n_cmp++;
        if (acc !== 65026 || sat !== 1'b0) begin
            n_err++;
            $display("FAIL gaps_value: got %0d/%0b want 65026/0", acc, sat);
        end
    endtask

    task automatic test_sat_pos();
        longint acc; bit sat;
        for (int i = 0; i < 130; i++) set_pair(i, 255, 0, 255, 0);
        do_run(130, 0, 1'b0, "sat_pos130", acc, sat);
        n_cmp++;
        if (acc !== 8388607 || sat !== 1'b1) begin
            n_err++;
            $display("FAIL sat_pos130_value: got %0d/%0b want 8388607/1", acc, sat);
        end
        do_run(129, 0, 1'b0, "pos129", acc, sat);
        n_cmp++;
        if (acc !== 8388225 || sat !== 1'b0) begin
            n_err++;
            $display("FAIL pos129_value: got %0d/%0b want 8388225/0", acc, sat);
        end
    endtask

    task automatic test_sat_neg();
        longint acc; bit sat;
        for (int i = 0; i < 131; i++) set_pair(i, 255, 1, 255, 0);
        set_pair(5, 0, 1, 9, 0);
        do_run(131, 2, 1'b0, "sat_neg", acc, sat);
        n_cmp++;
        if (acc !== -8388608 || sat !== 1'b1) begin
            n_err++;
            $display("FAIL sat_neg_value: got %0d/%0b want -8388608/1", acc, sat);
        end
        set_pair(0, 0, 1, 9, 0);
        set_pair(1, 1, 0, 1, 1);
        do_run(2, 0, 1'b0, "neg_zero", acc, sat);
        n_cmp++;
        if (acc !== -1 || sat !== 1'b0) begin
            n_err++;
            $display("FAIL neg_zero_value: got %0d/%0b want -1/0", acc, sat);
        end
    endtask

    task automatic test_len0_hold();
        @(negedge clk);
        vif.out_ready = 1'b0;
        vif.start = 1'b1;
        vif.len   = '0;
        @(posedge clk);
        @(negedge clk);
        vif.start = 1'b0;
        n_cmp++;
        if (vif.out_valid !== 1'b1 || vif.out_acc !== '0 || vif.out_sat !== 1'b0 || vif.busy !== 1'b1) begin
            n_err++;
            $display("FAIL len0_result: got ov=%b acc=%0d sat=%b busy=%b want 1 0 0 1",
                     vif.out_valid, vif.out_acc, vif.out_sat, vif.busy);
        end
        for (int k = 0; k < 5; k++) begin
            vif.start = k[0];
            vif.len   = 8'd5;
            @(posedge clk);
            @(negedge clk);
            n_cmp++;
            if (vif.out_valid !== 1'b1 || vif.out_acc !== '0 || vif.busy !== 1'b1 || vif.in_ready !== 1'b0) begin
                n_err++;
                $display("FAIL len0_hold%0d: got ov=%b acc=%0d busy=%b rdy=%b want 1 0 1 0",
                         k, vif.out_valid, vif.out_acc, vif.busy, vif.in_ready);
            end
        end
        vif.start = 1'b0;
        vif.out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        n_cmp++;
        if (vif.out_valid !== 1'b0 || vif.busy !== 1'b0) begin
            n_err++;
            $display("FAIL len0_release: got ov=%b busy=%b want 0 0", vif.out_valid, vif.busy);
        end
    endtask

    task automatic test_reset_midrun();
        longint acc; bit sat;
        int acc_cnt = 0;
        int t = 0;
        bit hs;
        @(negedge clk);
        vif.start = 1'b1;
        vif.len   = 8'd4;
        @(posedge clk);
        @(negedge clk);
        vif.start = 1'b0;
        while (acc_cnt < 2 && t < 50) begin
            vif.in_valid = 1'b1;
            vif.a_mag = 8'd9; vif.a_sign = 1'b0;
            vif.b_mag = 8'd7; vif.b_sign = 1'b0;
            hs = vif.in_ready;
            @(posedge clk);
            t++;
            if (hs) acc_cnt++;
            @(negedge clk);
        end
        vif.in_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if ({vif.busy, vif.in_ready, vif.out_valid, vif.out_sat} !== 4'b0 || vif.out_acc !== '0 ||
            {vif.mul_a, vif.mul_b, vif.mul_asign, vif.mul_bsign} !== 18'd0) begin
            n_err++;
            $display("FAIL midrun_reset: got busy=%b rdy=%b ov=%b acc=%0d mul_a=%0d want all 0",
                     vif.busy, vif.in_ready, vif.out_valid, vif.out_acc, vif.mul_a);
        end
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            n_cmp++;
            if (vif.out_valid !== 1'b0 || vif.busy !== 1'b0) begin
                n_err++;
                $display("FAIL midrun_no_partial: got ov=%b busy=%b want 0 0", vif.out_valid, vif.busy);
            end
        end
        set_pair(0, 4, 0, 4, 0);
        do_run(1, 0, 1'b0, "after_reset", acc, sat);
        n_cmp++;
        if (acc !== 16 || sat !== 1'b0) begin
            n_err++;
            $display("FAIL after_reset_value: got %0d/%0b want 16/0", acc, sat);
        end
    endtask

    task automatic test_random();
        longint acc; bit sat;
        int n;
        for (int r = 0; r < 6; r++) begin
            n = int'($urandom_range(1, 60));
            for (int i = 0; i < n; i++)
                set_pair(i, $urandom_range(0, 255), 1'($urandom), $urandom_range(0, 255), 1'($urandom));
            do_run(n, 2, 1'b0, "random", acc, sat);
        end
    endtask

    initial begin
        rst_n         = 1'b0;
        vif.start     = 1'b0;
        vif.len       = '0;
        vif.in_valid  = 1'b0;
        vif.a_mag     = '0;
        vif.a_sign    = 1'b0;
        vif.b_mag     = '0;
        vif.b_sign    = 1'b0;
        vif.out_ready = 1'b1;
        test_reset();
        test_contig();
        test_gaps();
        test_sat_pos();
        test_sat_neg();
        test_len0_hold();
        test_reset_midrun();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
